alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter NOP_OPCODE, default 6'h21, ALU opcode driven at reset and for illegal instructions.
REQ-002 Parameter CNT_W, default 16, width of illegal-instruction counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  discard all buffered beats.
REQ-006 in_valid / in_ready  input / output  1 / 1  upstream handshake; beat accepted when both high at a clock edge.
REQ-007 instr  input  32  MIPS instruction word.
REQ-008 rs_data, rt_data  input  32 each  register-file read values for instr[25:21], instr[20:16].
REQ-009 out_valid / out_ready  output / input  1 / 1  downstream handshake to ALU stage.
REQ-010 alu_opcode  output  6  ALU operation code.
REQ-011 op1, op2  output  32 each  ALU operands.
REQ-012 dest_reg  output  5  write-back register index.
REQ-013 illegal  output  1  current beat is unsupported.
REQ-014 illegal_cnt  output  CNT_W  saturating count of accepted illegal beats.

Function
REQ-015 R-type (instr[31:26]==0), funct in {20,21,22,23,24,25,26,27,2A,2B,00,02,03,04,06,07}: alu_opcode SHALL equal funct; dest_reg = instr[15:11].
REQ-016 R-type non-shift: op1 = rs_data, op2 = rt_data.
REQ-017 sll/srl/sra (funct 00/02/03): op1 = {27'b0, instr[10:6]}, op2 = rt_data.
REQ-018 sllv/srlv/srav (funct 04/06/07): op1 = {27'b0, rs_data[4:0]}, op2 = rt_data.
REQ-019 I-type opcode in {08,09,0A,0B}: alu_opcode = opcode, op1 = rs_data, op2 = sign-extended instr[15:0]; dest_reg = instr[20:16].
REQ-020 I-type opcode in {0C,0D,0E}: as REQ-019 but op2 zero-extended.
REQ-021 lui (0F): alu_opcode = 6'h0F, op1 = 0, op2 = {16'b0, instr[15:0]}.
REQ-022 lw (23) / sw (2B): alu_opcode = 6'h21, op1 = rs_data, op2 = sign-extended imm; dest_reg = instr[20:16] for lw, 0 for sw.
REQ-023 Any other encoding: illegal = 1, alu_opcode = NOP_OPCODE, op1 = op2 = 0, dest_reg = 0.
REQ-024 Decoding is combinational on input; results registered; latency in->out exactly one cycle when output stage empty.
REQ-025 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Output stage empty or out_ready=1: new beat may be accepted in the same cycle the old one leaves (full throughput, one beat per cycle).
REQ-027 illegal_cnt increments by 1 on each accepted illegal beat; holds at all-ones.
REQ-028 flush=1: all valid flags cleared at that edge, in_ready=0 that cycle, no beat accepted; illegal_cnt unaffected.

Reset
REQ-029 rst_n low: out_valid=0, illegal=0, illegal_cnt=0, alu_opcode=NOP_OPCODE, op1=op2=0, dest_reg=0, skid entry empty, immediately and asynchronously.
REQ-030 in_ready SHALL be 0 while rst_n low and 1 the first cycle after release.

Configuration
REQ-031 Macro ALU_ISSUE_SKID_EN defined: one-entry skid buffer added; in_ready is a register (=skid empty), no combinational out_ready->in_ready path; beat arriving while output stalled goes to skid, drains first.
REQ-032 Macro undefined: single output register; in_ready = !out_valid || out_ready combinationally (gated by flush).

Structure
REQ-033 Shared package alu_pkg SHALL hold opcode/funct constants, ALU opcode constants, and the decoded-beat struct {alu_opcode, op1, op2, dest_reg, illegal}.
REQ-034 Combinational decode SHALL be sub-module alu_issue_dec; alu_issue holds handshake, skid, and counter.

Verification
REQ-035 add $3,$1,$2 (0x00221820), rs=5, rt=7, out_ready=1 -> next cycle alu_opcode=20, op1=5, op2=7, dest=3.
REQ-036 addi $4,$1,-1 (0x2024FFFF), rs=10 -> op2=32'hFFFFFFFF, opcode 08, dest=4; ori same imm -> op2=32'h0000FFFF.
REQ-037 sll $2,$3,4 (0x00031100), rt=1 -> op1=4, op2=1, opcode 00; lui $5,0x1234 -> op1=0, op2=0x1234, opcode 0F.
REQ-038 Back-to-back 3 beats, out_ready low 2 cycles mid-stream -> no loss/duplication, order preserved, fields stable while stalled; with SKID_EN in_ready never depends on same-cycle out_ready.
REQ-039 Opcode 0x3F word -> illegal=1, alu_opcode=21, illegal_cnt 0->1; preload near saturation -> holds at 16'hFFFF.
REQ-040 Flush with full output and skid, then rst_n pulse mid-stream -> out_valid=0 next edge / immediately, all outputs at reset values, counter 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared decode constants and the decoded-beat type for the ALU issue stage.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [5:0] ALU_ADDU    = 6'h21;
  localparam logic [5:0] ALU_LUI     = 6'h0F;
  localparam logic [5:0] ALU_NOP_DEF = 6'h21;

  typedef enum logic [2:0] {
    CLS_R_ALU,
    CLS_SHIFT_IMM,
    CLS_SHIFT_VAR,
    CLS_I_SEXT,
    CLS_I_ZEXT,
    CLS_LUI,
    CLS_MEM,
    CLS_ILLEGAL
  } dec_cls_e;

  typedef struct packed {
    logic [5:0]  alu_opcode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  dest_reg;
    logic        illegal;
  } dec_beat_t;

  function automatic dec_beat_t idle_beat(input logic [5:0] nop_opcode);
    dec_beat_t b;
    b.alu_opcode = nop_opcode;
    b.op1        = '0;
    b.op2        = '0;
    b.dest_reg   = '0;
    b.illegal    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Upstream/downstream handshake bundle of the ALU issue stage.
// master = instruction source and ALU sink side, slave = alu_issue.
interface alu_issue_if #(parameter int CNT_W = 16);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [31:0]       rs_data;
  logic [31:0]       rt_data;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        alu_opcode;
  logic [31:0]       op1;
  logic [31:0]       op2;
  logic [4:0]        dest_reg;
  logic              illegal;
  logic [CNT_W-1:0]  illegal_cnt;

  // A beat moves on a side when valid and ready are both high at a rising edge;
  // once out_valid is high the output fields hold until out_ready takes them.
  modport master (
    output in_valid, instr, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, alu_opcode, op1, op2, dest_reg, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, rs_data, rt_data, out_ready,
    output in_ready, out_valid, alu_opcode, op1, op2, dest_reg, illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_issue_dec.sv
// Combinational MIPS decode: classify the instruction word, then build the ALU beat.
module alu_issue_dec
  import alu_pkg::*;
#(
  parameter logic [5:0] NOP_OPCODE = ALU_NOP_DEF
) (
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output dec_beat_t   beat
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  dec_cls_e    cls;
  logic        unused_rs_idx;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'b0, instr[15:0]};
  // Register indices were already consumed by the register-file read.
  assign unused_rs_idx = ^instr[25:21];

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_SRL, F_SRA:    cls = CLS_SHIFT_IMM;
          F_SLLV, F_SRLV, F_SRAV: cls = CLS_SHIFT_VAR;
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU:          cls = CLS_R_ALU;
          default:                cls = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: cls = CLS_I_SEXT;
      OP_ANDI, OP_ORI, OP_XORI:             cls = CLS_I_ZEXT;
      OP_LUI:                               cls = CLS_LUI;
      OP_LW, OP_SW:                         cls = CLS_MEM;
      default:                              cls = CLS_ILLEGAL;
    endcase
  end

  always_comb begin
    beat = idle_beat(NOP_OPCODE);
    case (cls)
      CLS_R_ALU: begin
        beat.alu_opcode = funct;
        beat.op1        = rs_data;
        beat.op2        = rt_data;
        beat.dest_reg   = instr[15:11];
      end
      CLS_SHIFT_IMM: begin
        beat.alu_opcode = funct;
        beat.op1        = {27'b0, instr[10:6]};
        beat.op2        = rt_data;
        beat.dest_reg   = instr[15:11];
      end
      CLS_SHIFT_VAR: begin
        beat.alu_opcode = funct;
        beat.op1        = {27'b0, rs_data[4:0]};
        beat.op2        = rt_data;
        beat.dest_reg   = instr[15:11];
      end
      CLS_I_SEXT, CLS_I_ZEXT: begin
        beat.alu_opcode = opcode;
        beat.op1        = rs_data;
        beat.op2        = (cls == CLS_I_SEXT) ? imm_sext : imm_zext;
        beat.dest_reg   = instr[20:16];
      end
      CLS_LUI: begin
        beat.alu_opcode = ALU_LUI;
        beat.op2        = imm_zext;
        beat.dest_reg   = instr[20:16];
      end
      CLS_MEM: begin
        // Loads and stores only need the address sum from the ALU.
        beat.alu_opcode = ALU_ADDU;
        beat.op1        = rs_data;
        beat.op2        = imm_sext;
        beat.dest_reg   = (opcode == OP_LW) ? instr[20:16] : 5'd0;
      end
      default: beat.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decoded beat registered behind a valid/ready handshake,
// saturating illegal counter. Define ALU_ISSUE_SKID_EN for a one-entry skid buffer.
module alu_issue
  import alu_pkg::*;
#(
  parameter logic [5:0] NOP_OPCODE = ALU_NOP_DEF,
  parameter int         CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  alu_issue_if.slave    bus
);

  localparam dec_beat_t RESET_BEAT = '{alu_opcode: NOP_OPCODE, op1: 32'd0,
                                       op2: 32'd0, dest_reg: 5'd0, illegal: 1'b0};

  dec_beat_t         dec_beat;
  dec_beat_t         out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready;
  logic              accept;

  alu_issue_dec #(.NOP_OPCODE(NOP_OPCODE)) u_dec (
    .instr   (bus.instr),
    .rs_data (bus.rs_data),
    .rt_data (bus.rt_data),
    .beat    (dec_beat)
  );

  assign accept = bus.in_valid && in_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_beat.illegal && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

`ifdef ALU_ISSUE_SKID_EN
  dec_beat_t skid_q, skid_d;
  logic      skid_valid_q, skid_valid_d;

  // Ready follows only the skid occupancy, never the same-cycle out_ready.
  assign in_ready = rst_n && !flush && !skid_valid_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= RESET_BEAT;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = rst_n && !flush && (!out_valid_q || bus.out_ready);

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec_beat;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= RESET_BEAT;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.alu_opcode  = out_q.alu_opcode;
  assign bus.op1         = out_q.op1;
  assign bus.op2         = out_q.op2;
  assign bus.dest_reg    = out_q.dest_reg;
  assign bus.illegal     = out_q.illegal;
  assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed spec examples, randomized stream against a
// rule-level decode model with an expected queue, flush, saturation and reset.
module tb_alu_issue;

  logic clk;
  logic rst_n;
  logic flush;
  logic flush_s;

  alu_issue_if #(.CNT_W(16)) bus ();
  alu_issue_if #(.CNT_W(3))  bus_s ();

  alu_issue #(.NOP_OPCODE(6'h21), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave)
  );

  alu_issue #(.NOP_OPCODE(6'h21), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush_s), .bus(bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [75:0] exp_q[$];
  int model_cnt = 0;

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [75:0] obs_beat();
    return {bus.alu_opcode, bus.op1, bus.op2, bus.dest_reg, bus.illegal};
  endfunction

  // Reference decode written straight from the instruction-set rules.
  function automatic logic [75:0] ref_dec(input logic [31:0] ins, input logic [31:0] rs,
                                          input logic [31:0] rt);
    logic [5:0]  op, fn, a;
    logic [31:0] se, ze, x, y;
    logic [4:0]  d;
    logic        il;
    op = ins[31:26]; fn = ins[5:0];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    a = 6'h21; x = 0; y = 0; d = 0; il = 0;
    if (op == 6'h00 && fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
      a = fn; d = ins[15:11]; y = rt;
      if (fn inside {6'h00, 6'h02, 6'h03})      x = 32'(ins[10:6]);
      else if (fn inside {6'h04, 6'h06, 6'h07}) x = 32'(rs[4:0]);
      else                                      x = rs;
    end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B}) begin
      a = op; x = rs; y = se; d = ins[20:16];
    end else if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
      a = op; x = rs; y = ze; d = ins[20:16];
    end else if (op == 6'h0F) begin
      a = 6'h0F; y = ze; d = ins[20:16];
    end else if (op == 6'h23) begin
      x = rs; y = se; d = ins[20:16];
    end else if (op == 6'h2B) begin
      x = rs; y = se;
    end else begin
      il = 1;
    end
    return {a, x, y, d, il};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] rfun [16];
    logic [5:0] iops [10];
    logic [31:0] w;
    rfun = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    iops = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    w = $urandom;
    case ($urandom_range(0, 4))
      0, 1: w = {6'h00, w[25:6], rfun[$urandom_range(0, 15)]};
      2, 3: w = {iops[$urandom_range(0, 9)], w[25:0]};
      default: ;
    endcase
    return w;
  endfunction

  // One beat into an empty, ready output stage; result must appear one cycle later.
  task automatic send_one(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                          input logic [31:0] rt, output logic [75:0] obs);
    logic [75:0] e;
    @(posedge clk); #1;
    bus.in_valid = 1; bus.instr = ins; bus.rs_data = rs; bus.rt_data = rt; bus.out_ready = 1;
    @(negedge clk);
    check({tag, "_in_ready"}, 76'(bus.in_ready), 76'(1));
    e = ref_dec(ins, rs, rt);
    @(posedge clk); #1;
    bus.in_valid = 0;
    if (e[0]) model_cnt++;
    check({tag, "_out_valid"}, 76'(bus.out_valid), 76'(1));
    check({tag, "_beat"}, obs_beat(), e);
    check({tag, "_cnt"}, 76'(bus.illegal_cnt), 76'(model_cnt));
    obs = obs_beat();
  endtask

  initial begin
    logic [75:0] ob, hold_v, e;
    logic        stalled_prev;
    logic [15:0] cnt_before;
    int          acc;

    rst_n = 0; flush = 0; flush_s = 0;
    bus.in_valid = 0; bus.instr = 0; bus.rs_data = 0; bus.rt_data = 0; bus.out_ready = 0;
    bus_s.in_valid = 0; bus_s.instr = 0; bus_s.rs_data = 0; bus_s.rt_data = 0; bus_s.out_ready = 0;
    #12;
    check("rst_out_valid", 76'(bus.out_valid), 76'(0));
    check("rst_in_ready", 76'(bus.in_ready), 76'(0));
    check("rst_beat", obs_beat(), {6'h21, 32'h0, 32'h0, 5'h0, 1'b0});
    check("rst_cnt", 76'(bus.illegal_cnt), 76'(0));
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 76'(bus.in_ready), 76'(1));

    send_one("add", 32'h00221820, 32'd5, 32'd7, ob);
    check("add_const", ob, {6'h20, 32'd5, 32'd7, 5'd3, 1'b0});
    send_one("addi", 32'h2024FFFF, 32'd10, 32'd0, ob);
    check("addi_const", ob, {6'h08, 32'd10, 32'hFFFFFFFF, 5'd4, 1'b0});
    send_one("ori", 32'h3424FFFF, 32'd10, 32'd0, ob);
    check("ori_const", ob, {6'h0D, 32'd10, 32'h0000FFFF, 5'd4, 1'b0});
    send_one("sll", 32'h00031100, 32'd9, 32'd1, ob);
    check("sll_const", ob, {6'h00, 32'd4, 32'd1, 5'd2, 1'b0});
    send_one("lui", 32'h3C051234, 32'd9, 32'd9, ob);
    check("lui_const", ob, {6'h0F, 32'd0, 32'h1234, 5'd5, 1'b0});
    send_one("sw", 32'hAC22FFF8, 32'd100, 32'd3, ob);
    check("sw_const", ob, {6'h21, 32'd100, 32'hFFFFFFF8, 5'd0, 1'b0});
    send_one("illegal", 32'hFC000000, 32'd1, 32'd2, ob);
    check("illegal_const", ob, {6'h21, 32'd0, 32'd0, 5'd0, 1'b1});
    check("illegal_cnt_1", 76'(bus.illegal_cnt), 76'(1));

    // Randomized stream with random backpressure.
    stalled_prev = 0; hold_v = '0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.instr     = rand_instr();
      bus.rs_data   = $urandom;
      bus.rt_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
`ifdef ALU_ISSUE_SKID_EN
      begin
        logic r0;
        r0 = bus.in_ready;
        bus.out_ready = !bus.out_ready; #1;
        check("skid_ready_indep", 76'(bus.in_ready), 76'(r0));
        bus.out_ready = !bus.out_ready; #1;
      end
`endif
      if (stalled_prev) begin
        check("stall_valid", 76'(bus.out_valid), 76'(1));
        check("stall_stable", obs_beat(), hold_v);
      end
      check("rand_cnt", 76'(bus.illegal_cnt), 76'(model_cnt));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("rand_spurious_beat", 76'(1), 76'(0));
        else check("rand_beat", obs_beat(), exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        e = ref_dec(bus.instr, bus.rs_data, bus.rt_data);
        exp_q.push_back(e);
        if (e[0]) model_cnt++;
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      hold_v = obs_beat();
    end
    @(posedge clk); #1;
    bus.in_valid = 0; bus.out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("drain_spurious_beat", 76'(1), 76'(0));
        else check("drain_beat", obs_beat(), exp_q.pop_front());
      end
    end
    check("drain_empty", 76'(exp_q.size()), 76'(0));

    // Stall the output, fill every buffer with illegal beats, then flush.
    @(posedge clk); #1;
    bus.out_ready = 0; bus.in_valid = 1; bus.instr = 32'hFC000000;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin acc++; model_cnt++; end
      @(posedge clk); #1;
    end
    check("fill_stalls_input", 76'(bus.in_ready), 76'(0));
    check("fill_out_valid", 76'(bus.out_valid), 76'(1));
    flush = 1;
    #1;
    check("flush_in_ready", 76'(bus.in_ready), 76'(0));
    cnt_before = bus.illegal_cnt;
    check("fill_cnt", 76'(cnt_before), 76'(model_cnt));
    @(posedge clk); #1;
    flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    check("flush_out_valid", 76'(bus.out_valid), 76'(0));
    check("flush_cnt_kept", 76'(bus.illegal_cnt), 76'(cnt_before));
    @(posedge clk); #1;
    check("flush_skid_cleared", 76'(bus.out_valid), 76'(0));
    check("flush_in_ready_back", 76'(bus.in_ready), 76'(1));

    // Counter saturation on a 3-bit instance.
    bus_s.in_valid = 1; bus_s.instr = 32'hFC000000; bus_s.out_ready = 1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      check($sformatf("sat_cnt_%0d", c), 76'(bus_s.illegal_cnt), 76'((c > 7) ? 7 : c));
    end
    bus_s.in_valid = 0;

    // Asynchronous reset in the middle of a stalled stream.
    bus.out_ready = 0; bus.in_valid = 1; bus.instr = 32'h00221820;
    bus.rs_data = 32'd5; bus.rt_data = 32'd7;
    @(posedge clk); #1;
    check("pre_rst_out_valid", 76'(bus.out_valid), 76'(1));
    #2 rst_n = 0;
    #1;
    check("async_rst_out_valid", 76'(bus.out_valid), 76'(0));
    check("async_rst_beat", obs_beat(), {6'h21, 32'h0, 32'h0, 5'h0, 1'b0});
    check("async_rst_cnt", 76'(bus.illegal_cnt), 76'(0));
    check("async_rst_in_ready", 76'(bus.in_ready), 76'(0));
    check("async_rst_sat_cnt", 76'(bus_s.illegal_cnt), 76'(0));
    bus.in_valid = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("rerst_in_ready", 76'(bus.in_ready), 76'(1));
    check("rerst_out_valid", 76'(bus.out_valid), 76'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
